// File: rtl/encoder8to3_pkg.sv
// Shared types and helpers for the 8-to-3 request queue.
// Optional feature macro: ROUND_ROBIN_EN (rotating pick base).
package encoder8to3_pkg;

   localparam int N     = 8;
   localparam int IDX_W = $clog2(N);

   typedef enum logic {IDLE, HOLD} state_t;

   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   function automatic logic [IDX_W:0] popcount(input logic [N-1:0] vec);
      popcount = '0;
      for (int i = 0; i < N; i++)
         popcount = popcount + {{IDX_W{1'b0}}, vec[i]};
   endfunction

endpackage

// File: rtl/encoder8to3_req_queue_prio_enc8.sv
// Rotating-base priority encoder: first set bit at or above base, wrapping.
// Base tied to 0 gives plain lowest-index-first priority.
module prio_enc8
   import encoder8to3_pkg::*;
(
   input  logic [N-1:0]     vec,
   input  logic [IDX_W-1:0] base,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [IDX_W-1:0] j;

   // Scan from farthest to nearest offset so the nearest set bit wins
   always_comb begin
      idx   = '0;
      j     = '0;
      found = |vec;
      for (int i = N - 1; i >= 0; i--) begin
         j = base + IDX_W'(i);
         if (vec[j])
            idx = j;
      end
   end

endmodule

// File: rtl/encoder8to3_req_queue.sv
// Collects request bits and issues each as a 3-bit index over valid/ready.
// Optional feature macro: ROUND_ROBIN_EN (fair rotating pick).
module encoder8to3_req_queue
   import encoder8to3_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N-1:0]     in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out,
   output logic [IDX_W:0]   pend_cnt,
   output logic             merge
);

   state_t           state_q, state_d;
   logic [N-1:0]     pending_q, pending_d;
   logic [IDX_W-1:0] out_q, out_d;
   logic [IDX_W:0]   pend_cnt_q, pend_cnt_d;
   logic             merge_q, merge_d;
   logic [IDX_W-1:0] base;
   logic [IDX_W-1:0] pick;
   logic             found;
   logic             load;
   logic [N-1:0]     clr;
   logic [N-1:0]     set;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   assign base = rr_ptr_q;

   // Pointer moves just past the last issued index
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (load)
         rr_ptr_d = pick + 1'b1;
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr_q <= '0;
      else
         rr_ptr_q <= rr_ptr_d;
   end
`else
   assign base = '0;
`endif

   prio_enc8 u_prio (
      .vec   (pending_q),
      .base  (base),
      .idx   (pick),
      .found (found)
   );

   // Handshake FSM: decide load and next output
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               load    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (found)
                  load = 1'b1;
               else
                  state_d = IDLE;
            end
         end
      endcase
      if (load)
         out_d = pick;
   end

   // Pending set/clear; a same-cycle set overrides the clear
   always_comb begin
      clr        = load ? onehot(pick) : '0;
      set        = en ? in : '0;
      pending_d  = (pending_q & ~clr) | set;
      merge_d    = |(set & pending_q & ~clr);
      pend_cnt_d = popcount(pending_d);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         out_q      <= '0;
         pend_cnt_q <= '0;
         merge_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         out_q      <= out_d;
         pend_cnt_q <= pend_cnt_d;
         merge_q    <= merge_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out       = out_q;
   assign pend_cnt  = pend_cnt_q;
   assign merge     = merge_q;

endmodule

// File: tb/tb_encoder8to3_req_queue.sv
// Scoreboard bench for encoder8to3_req_queue.
// Expected indices are queued at stimulus time and popped on each transfer.
module tb_encoder8to3_req_queue;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] in;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out;
   logic [3:0] pend_cnt;
   logic       merge;

   int vec_cnt;
   int err_cnt;
   int exp_q[$];

   encoder8to3_req_queue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in        (in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out       (out),
      .pend_cnt  (pend_cnt),
      .merge     (merge)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      en        = 1'b1;
      in        = 8'hFF;
      out_ready = 1'b0;
      step();
      step();
      vec_cnt++;
      if (out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_valid got %0b want 0", out_valid);
      end
      vec_cnt++;
      if (pend_cnt !== 4'd0) begin
         err_cnt++;
         $display("FAIL reset_cnt got %0d want 0", pend_cnt);
      end
      vec_cnt++;
      if (merge !== 1'b0 || out !== 3'd0) begin
         err_cnt++;
         $display("FAIL reset_mo got merge=%0b out=%0d want 0 0", merge, out);
      end
      en    = 1'b0;
      in    = 8'h00;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int e;
      out_ready = 1'b1;
      en        = 1'b1;
      in        = 8'b0010_0000;
      exp_q.push_back(5);
      step();
      en = 1'b0;
      in = 8'h00;
      vec_cnt++;
      if (pend_cnt !== 4'd1 || out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_t1 got cnt=%0d v=%0b want 1 0", pend_cnt, out_valid);
      end
      step();
      vec_cnt++;
      if (out_valid !== 1'b1 || pend_cnt !== 4'd0) begin
         err_cnt++;
         $display("FAIL single_t2 got v=%0b cnt=%0d want 1 0", out_valid, pend_cnt);
      end
      if (out_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (out !== 3'(e)) begin
            err_cnt++;
            $display("FAIL single_idx got %0d want %0d", out, e);
         end
      end
      step();
      vec_cnt++;
      if (out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_once got v=%0b want 0", out_valid);
      end
      exp_q.delete();
   endtask

   task automatic test_multi_fixed();
      int e;
      int first_c;
      int last_c;
      first_c   = -1;
      last_c    = -1;
      out_ready = 1'b1;
      en        = 1'b1;
      in        = 8'b1000_1010;
      exp_q.push_back(1);
      exp_q.push_back(3);
      exp_q.push_back(7);
      step();
      en = 1'b0;
      in = 8'h00;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (out !== 3'(e)) begin
               err_cnt++;
               $display("FAIL multi_idx got %0d want %0d", out, e);
            end
            if (first_c < 0)
               first_c = c;
            last_c = c;
         end
         step();
      end
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL multi_timeout got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      vec_cnt++;
      if (last_c - first_c != 2) begin
         err_cnt++;
         $display("FAIL multi_b2b got span=%0d want 2", last_c - first_c);
      end
      vec_cnt++;
      if (out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL multi_idle got v=%0b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      int e;
      out_ready = 1'b0;
      en        = 1'b1;
      in        = 8'h81;
      exp_q.push_back(0);
      exp_q.push_back(7);
      step();
      en = 1'b0;
      in = 8'h00;
      step();
      for (int k = 0; k < 5; k++) begin
         vec_cnt++;
         if (out_valid !== 1'b1 || out !== 3'd0 || pend_cnt !== 4'd1) begin
            err_cnt++;
            $display("FAIL bp_hold got v=%0b out=%0d cnt=%0d want 1 0 1",
                     out_valid, out, pend_cnt);
         end
         step();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (out !== 3'(e)) begin
               err_cnt++;
               $display("FAIL bp_idx got %0d want %0d", out, e);
            end
         end
         step();
      end
      vec_cnt++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL bp_end got left=%0d v=%0b want 0 0", exp_q.size(), out_valid);
         exp_q.delete();
      end
   endtask

   task automatic test_merge();
      int e;
      out_ready = 1'b0;
      en        = 1'b1;
      in        = 8'h05;
      exp_q.push_back(0);
      exp_q.push_back(2);
      step();
      en = 1'b0;
      in = 8'h00;
      step();
      en = 1'b1;
      in = 8'h04;
      step();
      en = 1'b0;
      in = 8'h00;
      vec_cnt++;
      if (merge !== 1'b1 || pend_cnt !== 4'd1) begin
         err_cnt++;
         $display("FAIL merge_pulse got m=%0b cnt=%0d want 1 1", merge, pend_cnt);
      end
      step();
      vec_cnt++;
      if (merge !== 1'b0) begin
         err_cnt++;
         $display("FAIL merge_width got %0b want 0", merge);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (out !== 3'(e)) begin
               err_cnt++;
               $display("FAIL merge_idx got %0d want %0d", out, e);
            end
         end
         step();
      end
      vec_cnt++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL merge_end got left=%0d v=%0b want 0 0", exp_q.size(), out_valid);
         exp_q.delete();
      end
   endtask

   task automatic test_round_robin();
      int e;
      out_ready = 1'b1;
      en        = 1'b1;
      in        = 8'h03;
      for (int k = 0; k < 6; k++) begin
`ifdef ROUND_ROBIN_EN
         exp_q.push_back(k % 2);
`else
         exp_q.push_back(0);
`endif
      end
      step();
      step();
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (out !== 3'(e)) begin
               err_cnt++;
               $display("FAIL rr_idx got %0d want %0d", out, e);
            end
         end
         step();
      end
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL rr_timeout got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      rst_n = 1'b0;
      step();
      vec_cnt++;
      if (out_valid !== 1'b0 || out !== 3'd0 || pend_cnt !== 4'd0 || merge !== 1'b0) begin
         err_cnt++;
         $display("FAIL rr_reset got v=%0b out=%0d cnt=%0d m=%0b want 0 0 0 0",
                  out_valid, out, pend_cnt, merge);
      end
      en    = 1'b0;
      in    = 8'h00;
      rst_n = 1'b1;
      step();
      step();
      vec_cnt++;
      if (out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL rr_after got v=%0b want 0", out_valid);
      end
   endtask

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      rst_n     = 1'b0;
      en        = 1'b0;
      in        = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_multi_fixed();
      test_backpressure();
      test_merge();
      test_round_robin();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
